vlsu_req_arb: RTL and testbench

VLSU_REQ_ARB -- requirements
Module: vlsu_req_arb

---
 rtl/riva_pkg.sv | 16 +
 rtl/vlsu_rr_pick.sv | 29 ++
 rtl/vlsu_req_arb.sv | 149 ++++++++++++++
 tb/tb_vlsu_req_arb.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riva_pkg.sv
// rtl/riva_pkg.sv - shared request payload and arbiter state types for the VLSU request arbiter
package riva_pkg;

    // Request payload handed from a source to the fragmenter.
    typedef struct packed {
        logic        isLoad;
        logic [14:0] data;
    } vlsu_req_t;

    // Output register occupancy.
    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } arb_state_e;

endpackage

// File: rtl/vlsu_rr_pick.sv
// rtl/vlsu_rr_pick.sv - combinational round-robin picker: first eligible source at or after the pointer
module vlsu_rr_pick #(
    parameter int unsigned NrReq = 2,
    parameter int unsigned SrcW  = (NrReq > 1) ? $clog2(NrReq) : 1
) (
    input  logic [NrReq-1:0] eligible_i,
    input  logic [SrcW-1:0]  ptr_i,
    output logic [NrReq-1:0] gnt_o,
    output logic [SrcW-1:0]  idx_o
);

    int unsigned cand;

    // Scan offsets from farthest to nearest so the nearest eligible source at/after ptr_i wins.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        cand  = 0;
        for (int unsigned k = 0; k < NrReq; k++) begin
            cand = (32'(ptr_i) + (NrReq - 1 - k)) % NrReq;
            if (eligible_i[cand[SrcW-1:0]]) begin
                gnt_o                   = '0;
                gnt_o[cand[SrcW-1:0]]   = 1'b1;
                idx_o                   = cand[SrcW-1:0];
            end
        end
    end

endmodule

// File: rtl/vlsu_req_arb.sv
// rtl/vlsu_req_arb.sv - credit-limited round-robin arbiter feeding one fragmenter; VLSU_ARB_ORDER_EN enables load/store ordering
module vlsu_req_arb #(
    parameter int unsigned NrReq    = 2,
    parameter int unsigned MaxOutst = 4,
    parameter type         vlsu_req_t = riva_pkg::vlsu_req_t,
    localparam int unsigned SrcW    = (NrReq > 1) ? $clog2(NrReq) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [NrReq-1:0] req_valid_i,
    output logic [NrReq-1:0] req_ready_o,
    input  vlsu_req_t        req_i [NrReq],
    output logic             frag_valid_o,
    input  logic             frag_ready_i,
    output vlsu_req_t        frag_req_o,
    output logic [SrcW-1:0]  frag_src_o,
    input  logic             done_valid_i,
    input  logic [SrcW-1:0]  done_src_i,
    input  logic             done_is_load_i,
    output logic             err_o
);

    import riva_pkg::*;

    localparam int unsigned CntW = $clog2(MaxOutst + 1);
    localparam int unsigned GlbW = $clog2(NrReq * MaxOutst + 1);

    arb_state_e       state;
    logic [SrcW-1:0]  rr_ptr;
    logic [CntW-1:0]  outst [NrReq];
    logic [NrReq-1:0] order_ok;
    logic [NrReq-1:0] eligible;
    logic [NrReq-1:0] gnt;
    logic [SrcW-1:0]  win_idx;
    logic             slot_free;
    logic             grant;
    logic [NrReq-1:0] done_hit;
    logic [NrReq-1:0] src_uflow;
    logic             glb_uflow;

`ifdef VLSU_ARB_ORDER_EN
    logic [GlbW-1:0] ld_outst;
    logic [GlbW-1:0] st_outst;
    logic            ld_inc, st_inc, ld_dec, st_dec;

    // A load waits for all stores to drain and vice versa; same class never blocks.
    always_comb begin
        for (int i = 0; i < NrReq; i++) begin
            order_ok[i] = req_i[i].isLoad ? (st_outst == '0) : (ld_outst == '0);
        end
    end

    // Class counters track what the fragmenter still owes.
    always_comb begin
        ld_inc    = grant && req_i[win_idx].isLoad;
        st_inc    = grant && !req_i[win_idx].isLoad;
        ld_dec    = done_valid_i && done_is_load_i;
        st_dec    = done_valid_i && !done_is_load_i;
        glb_uflow = (ld_dec && !ld_inc && ld_outst == '0) ||
                    (st_dec && !st_inc && st_outst == '0);
    end

    // Global load/store in-flight counters, saturating at zero on underflow.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ld_outst <= '0;
            st_outst <= '0;
        end else begin
            if (ld_inc && !ld_dec)                        ld_outst <= ld_outst + 1'b1;
            else if (ld_dec && !ld_inc && ld_outst != '0) ld_outst <= ld_outst - 1'b1;
            if (st_inc && !st_dec)                        st_outst <= st_outst + 1'b1;
            else if (st_dec && !st_inc && st_outst != '0) st_outst <= st_outst - 1'b1;
        end
    end
`else
    logic unused_done_is_load;
    assign unused_done_is_load = done_is_load_i;
    assign order_ok            = '1;
    assign glb_uflow           = 1'b0;
`endif

    // Eligibility: valid, below credit limit, ordering satisfied.
    always_comb begin
        for (int i = 0; i < NrReq; i++) begin
            eligible[i] = req_valid_i[i] && (outst[i] < CntW'(MaxOutst)) && order_ok[i];
            done_hit[i] = done_valid_i && (done_src_i == SrcW'(i));
        end
    end

    vlsu_rr_pick #(
        .NrReq (NrReq),
        .SrcW  (SrcW)
    ) u_pick (
        .eligible_i (eligible),
        .ptr_i      (rr_ptr),
        .gnt_o      (gnt),
        .idx_o      (win_idx)
    );

    assign slot_free    = (state == S_EMPTY) || frag_ready_i;
    assign grant        = slot_free && (|eligible) && !rst_i;
    assign req_ready_o  = grant ? gnt : '0;
    assign frag_valid_o = (state == S_FULL);

    // Output register: load on grant, drain on handshake, hold under backpressure.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= S_EMPTY;
            frag_req_o <= '0;
            frag_src_o <= '0;
        end else if (grant) begin
            state      <= S_FULL;
            frag_req_o <= req_i[win_idx];
            frag_src_o <= win_idx;
        end else if (frag_ready_i) begin
            state      <= S_EMPTY;
        end
    end

    // Round-robin pointer moves just past the most recent winner.
    always_ff @(posedge clk_i) begin
        if (rst_i)      rr_ptr <= '0;
        else if (grant) rr_ptr <= (win_idx == SrcW'(NrReq - 1)) ? '0 : win_idx + 1'b1;
    end

    // Underflow: a done for a source with nothing outstanding and no grant to offset it.
    always_comb begin
        for (int i = 0; i < NrReq; i++) begin
            src_uflow[i] = done_hit[i] && !req_ready_o[i] && (outst[i] == '0);
        end
    end

    // Per-source in-flight counters; simultaneous grant and done cancel out.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NrReq; i++) begin
            if (rst_i)                                        outst[i] <= '0;
            else if (req_ready_o[i] && !done_hit[i])          outst[i] <= outst[i] + 1'b1;
            else if (done_hit[i] && !req_ready_o[i] && outst[i] != '0)
                                                              outst[i] <= outst[i] - 1'b1;
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk_i) begin
        if (rst_i)                          err_o <= 1'b0;
        else if ((|src_uflow) || glb_uflow) err_o <= 1'b1;
    end

endmodule

// File: tb/tb_vlsu_req_arb.sv
// tb/tb_vlsu_req_arb.sv - self-checking bench for vlsu_req_arb with a behavioural reference model
module tb_vlsu_req_arb;
    import riva_pkg::*;

    localparam int N  = 2;
    localparam int MO = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    vlsu_req_t  req [N];
    logic       frag_valid;
    logic       frag_ready;
    vlsu_req_t  frag_req;
    logic [0:0] frag_src;
    logic       done_valid;
    logic [0:0] done_src;
    logic       done_is_load;
    logic       err;

    always #5 clk = ~clk;

    vlsu_req_arb dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_i          (req),
        .frag_valid_o   (frag_valid),
        .frag_ready_i   (frag_ready),
        .frag_req_o     (frag_req),
        .frag_src_o     (frag_src),
        .done_valid_i   (done_valid),
        .done_src_i     (done_src),
        .done_is_load_i (done_is_load),
        .err_o          (err)
    );

    int        n_tests = 0;
    int        n_fail  = 0;
    bit        m_valid = 0;
    vlsu_req_t m_req   = '0;
    int        m_src   = 0;
    int        m_rr    = 0;
    int        m_ld    = 0;
    int        m_st    = 0;
    int        m_outst [N] = '{0, 0};
    bit        m_err   = 0;
    int        exp_w;
    int        obs_w;
    vlsu_req_t hold;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: first source from the pointer that has a valid request, spare credit and ordering clearance.
    function automatic int model_pick();
        int c;
        bit ok;
        if (rst || !(!m_valid || frag_ready)) return -1;
        for (int k = 0; k < N; k++) begin
            c  = (m_rr + k) % N;
            ok = req_valid[c] && (m_outst[c] < MO);
`ifdef VLSU_ARB_ORDER_EN
            ok = ok && (req[c].isLoad ? (m_st == 0) : (m_ld == 0));
`endif
            if (ok) return c;
        end
        return -1;
    endfunction

    task automatic model_update();
        int v;
        bit li, si;
        if (rst) begin
            m_valid = 0; m_req = '0; m_src = 0; m_rr = 0;
            m_ld = 0; m_st = 0; m_outst = '{0, 0}; m_err = 0;
        end else begin
            for (int i = 0; i < N; i++) begin
                v = m_outst[i] + int'(exp_w == i) - int'(done_valid && (int'(done_src) == i));
                if (v < 0) begin v = 0; m_err = 1; end
                m_outst[i] = v;
            end
            li = (exp_w >= 0) && req[exp_w].isLoad;
            si = (exp_w >= 0) && !req[exp_w].isLoad;
            v = m_ld + int'(li) - int'(done_valid && done_is_load);
            if (v < 0) begin
                v = 0;
`ifdef VLSU_ARB_ORDER_EN
                m_err = 1;
`endif
            end
            m_ld = v;
            v = m_st + int'(si) - int'(done_valid && !done_is_load);
            if (v < 0) begin
                v = 0;
`ifdef VLSU_ARB_ORDER_EN
                m_err = 1;
`endif
            end
            m_st = v;
            if (exp_w >= 0) begin
                m_valid = 1; m_req = req[exp_w]; m_src = exp_w; m_rr = (exp_w + 1) % N;
            end else if (frag_ready) begin
                m_valid = 0;
            end
        end
    endtask

    // One clock: fresh payload data, compare at the falling edge, advance the model at the rising edge.
    task automatic cyc();
        logic [1:0] exp_rdy;
        for (int i = 0; i < N; i++) req[i].data = 15'($urandom);
        @(negedge clk);
        exp_w   = model_pick();
        exp_rdy = (exp_w < 0) ? 2'b00 : (2'b01 << exp_w);
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        obs_w = (req_ready == 2'b01) ? 0 : (req_ready == 2'b10) ? 1 : -1;
        chk("frag_valid", 64'(frag_valid), 64'(m_valid));
        chk("err", 64'(err), 64'(m_err));
        if (m_valid) begin
            chk("frag_src", 64'(frag_src), 64'(m_src));
            chk("frag_req", 64'(frag_req), 64'(m_req));
        end
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        rst = 1; req_valid = 2'b11; done_valid = 0;
        cyc();
        rst = 0; req_valid = 2'b00;
    endtask

    initial begin
        rst = 1; req_valid = 2'b11; frag_ready = 0;
        done_valid = 0; done_src = 0; done_is_load = 0;
        req[0] = '0; req[1] = '0;
        req[0].isLoad = 1; req[1].isLoad = 1;
        @(posedge clk); #1;
        cyc();
        chk("rst_frag_req", 64'(frag_req), 64'd0);
        chk("rst_frag_src", 64'(frag_src), 64'd0);
        chk("rst_outst0", 64'(dut.outst[0]), 64'd0);

        // Round-robin fairness, grant on first cycle after reset.
        rst = 0; req_valid = 2'b11; frag_ready = 1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("rr_seq", 64'(obs_w), 64'(i % 2));
            if (i == 0) chk("first_present", 64'(frag_valid), 64'd1);
        end
        do_reset();

        // Backpressure holds the entry and blocks all grants.
        req_valid = 2'b01; frag_ready = 1;
        cyc();
        frag_ready = 0; req_valid = 2'b11; hold = frag_req;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("bp_nogrant", 64'(obs_w), 64'(-1));
            chk("bp_stable", 64'(frag_req), 64'(hold));
        end
        frag_ready = 1;
        cyc();
        chk("bp_release_grant", 64'(obs_w), 64'd1);
        do_reset();

        // Credit limit.
        req_valid = 2'b01; frag_ready = 1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("credit_grant", 64'(obs_w), 64'd0);
        end
        cyc();
        chk("credit_stall", 64'(obs_w), 64'(-1));
        done_valid = 1; done_src = 0; done_is_load = 1;
        cyc();
        chk("credit_stall_done", 64'(obs_w), 64'(-1));
        done_valid = 0;
        cyc();
        chk("credit_after_done", 64'(obs_w), 64'd0);
        do_reset();

        // Load behind an in-flight store.
        req[1].isLoad = 0; req_valid = 2'b10;
        cyc();
        req[0].isLoad = 1; req_valid = 2'b01;
`ifdef VLSU_ARB_ORDER_EN
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("order_block", 64'(obs_w), 64'(-1));
        end
        done_valid = 1; done_src = 1; done_is_load = 0;
        cyc();
        chk("order_block_done", 64'(obs_w), 64'(-1));
        done_valid = 0;
        cyc();
        chk("order_release", 64'(obs_w), 64'd0);
`else
        cyc();
        chk("order_none", 64'(obs_w), 64'd0);
`endif
        do_reset();

        // Simultaneous grant+done, then underflow.
        req[0].isLoad = 1; req[1].isLoad = 1; req_valid = 2'b01;
        cyc();
        done_valid = 1; done_src = 0; done_is_load = 1;
        cyc();
        chk("simul_outst0", 64'(dut.outst[0]), 64'd1);
        req_valid = 2'b00; done_src = 1;
        cyc();
        chk("uflow_err", 64'(err), 64'd1);
        chk("uflow_outst1", 64'(dut.outst[1]), 64'd0);
        done_valid = 0;
        cyc();
        chk("err_sticky", 64'(err), 64'd1);
        do_reset();
        chk("err_cleared", 64'(err), 64'd0);

        // Reset mid-operation.
        req_valid = 2'b10;
        for (int i = 0; i < 3; i++) cyc();
        chk("mid_outst1", 64'(dut.outst[1]), 64'd3);
        chk("mid_valid", 64'(frag_valid), 64'd1);
        rst = 1; req_valid = 2'b11;
        cyc();
        chk("mid_rst_valid", 64'(frag_valid), 64'd0);
        chk("mid_rst_req", 64'(frag_req), 64'd0);
        chk("mid_rst_src", 64'(frag_src), 64'd0);
        chk("mid_rst_outst1", 64'(dut.outst[1]), 64'd0);
        chk("mid_rst_err", 64'(err), 64'd0);
        rst = 0;

        // Randomized traffic against the model; completions only for work actually in flight.
        for (int n = 0; n < 400; n++) begin
            int s;
            req_valid     = 2'($urandom);
            req[0].isLoad = 1'($urandom);
            req[1].isLoad = 1'($urandom);
            frag_ready    = ($urandom % 4) != 0;
            done_valid    = 0;
            s = int'($urandom % 2);
            if (m_outst[s] == 0) s = 1 - s;
            if (($urandom % 3) == 0 && m_outst[s] > 0) begin
                done_valid = 1;
                done_src   = 1'(s);
`ifdef VLSU_ARB_ORDER_EN
                done_is_load = (m_ld > 0) && ((m_st == 0) || 1'($urandom));
`else
                done_is_load = 1'($urandom);
`endif
            end
            cyc();
        end
        chk("rand_err_clear", 64'(err), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
